// File: rtl/tile_stream_pkg.sv
// tile_stream_pkg: shared types for the tile egress stream merger.
package tile_stream_pkg;
    localparam int LANES = 4;
    typedef logic [1:0] lane_idx_t;
    typedef enum logic {IDLE, LOCKED} merge_state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick starting after last_grant.
module rr_arbiter4
    import tile_stream_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  lane_idx_t        last_grant,
    output lane_idx_t        gnt_idx,
    output logic             gnt_any
);
    lane_idx_t cand;
    // Scan from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        gnt_idx = last_grant;
        cand = last_grant;
        gnt_any = |req;
        for (int k = LANES; k >= 1; k--) begin
            cand = last_grant + lane_idx_t'(k);
            if (req[cand]) gnt_idx = cand;
        end
    end
endmodule

// File: rtl/tile_stream_merge.sv
// tile_stream_merge: packet-level 4:1 AXI-stream merger with lane index on TDEST,
// per-lane packet counters and sticky malformed-TKEEP flags.
module tile_stream_merge
    import tile_stream_pkg::*;
#(
    parameter int BW    = 32,
    parameter int BWB   = BW / 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk_line,
    input  logic                   clk_line_rst_low,
    input  logic [LANES-1:0]       in_TVALID,
    input  logic [LANES*BW-1:0]    in_TDATA,
    input  logic [LANES*BWB-1:0]   in_TKEEP,
    input  logic [LANES-1:0]       in_TLAST,
    output logic [LANES-1:0]       in_TREADY,
    output logic                   out_TVALID,
    output logic [BW-1:0]          out_TDATA,
    output logic [BWB-1:0]         out_TKEEP,
    output logic                   out_TLAST,
    output lane_idx_t              out_TDEST,
    input  logic                   out_TREADY,
    output logic [LANES*CNT_W-1:0] pkt_cnt,
    output logic [LANES-1:0]       keep_err,
    input  logic                   err_clear
);
    merge_state_t     state, state_nx;
    lane_idx_t        grant, last_grant, pick;
    logic             pick_any, can_load, accept, beat_last;
    logic [BW-1:0]    beat_data;
    logic [BWB-1:0]   beat_keep;
    logic [LANES-1:0] grant_hot;

    rr_arbiter4 u_arb (
        .req        (in_TVALID),
        .last_grant (last_grant),
        .gnt_idx    (pick),
        .gnt_any    (pick_any)
    );

    assign can_load  = !out_TVALID || out_TREADY;
    assign accept    = (state == LOCKED) && in_TVALID[grant] && can_load;
    assign beat_data = in_TDATA[int'(grant)*BW +: BW];
    assign beat_keep = in_TKEEP[int'(grant)*BWB +: BWB];
    assign beat_last = in_TLAST[grant];
    assign grant_hot = LANES'(1) << grant;

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE) ? (pick_any ? LOCKED : IDLE)
                                   : ((accept && beat_last) ? IDLE : LOCKED);
    end

    always_comb begin
        in_TREADY = (state == LOCKED && can_load) ? grant_hot : '0;
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            grant      <= '0;
            last_grant <= lane_idx_t'(LANES - 1);
            out_TVALID <= 1'b0;
            out_TDATA  <= '0;
            out_TKEEP  <= '0;
            out_TLAST  <= 1'b0;
            out_TDEST  <= '0;
            pkt_cnt    <= '0;
            keep_err   <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                grant      <= pick;
                last_grant <= pick;
            end
            if (accept) begin
                out_TVALID <= 1'b1;
                out_TDATA  <= beat_data;
                out_TKEEP  <= beat_keep;
                out_TLAST  <= beat_last;
                out_TDEST  <= grant;
            end else if (out_TREADY) begin
                out_TVALID <= 1'b0;
            end
            if (accept && beat_last)
                pkt_cnt[int'(grant)*CNT_W +: CNT_W] <= pkt_cnt[int'(grant)*CNT_W +: CNT_W] + 1'b1;
            // A new error in the same cycle as a clear survives the clear.
            keep_err <= (err_clear ? '0 : keep_err)
                      | ((accept && !beat_last && beat_keep != '1) ? grant_hot : '0);
        end
    end
endmodule

// File: tb/tb_tile_stream_merge.sv
// tb_tile_stream_merge: randomized and directed checks of the 4:1 packet merger
// against a packet-order reference model.
module tb_tile_stream_merge;
    localparam int BW = 32, BWB = 4, CNT_W = 8;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      in_TVALID, in_TLAST, in_TREADY, keep_err;
    logic [127:0]    in_TDATA;
    logic [15:0]     in_TKEEP;
    logic            out_TVALID, out_TLAST, out_TREADY, err_clear;
    logic [31:0]     out_TDATA;
    logic [3:0]      out_TKEEP;
    logic [1:0]      out_TDEST;
    logic [31:0]     pkt_cnt;

    int          n_cmp = 0, n_bad = 0;
    beat_t       lq[4][$];
    logic [63:0] exp_q[$];
    int          exp_cnt[4];
    logic [3:0]  exp_err;
    int          model_last;

    always #5 clk = ~clk;

    tile_stream_merge #(.BW(BW), .BWB(BWB), .CNT_W(CNT_W)) dut (
        .clk_line         (clk),
        .clk_line_rst_low (rst_n),
        .in_TVALID        (in_TVALID),
        .in_TDATA         (in_TDATA),
        .in_TKEEP         (in_TKEEP),
        .in_TLAST         (in_TLAST),
        .in_TREADY        (in_TREADY),
        .out_TVALID       (out_TVALID),
        .out_TDATA        (out_TDATA),
        .out_TKEEP        (out_TKEEP),
        .out_TLAST        (out_TLAST),
        .out_TDEST        (out_TDEST),
        .out_TREADY       (out_TREADY),
        .pkt_cnt          (pkt_cnt),
        .keep_err         (keep_err),
        .err_clear        (err_clear)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic v, input logic [31:0] d, input logic [3:0] k, input logic last);
        in_TVALID[l]         = v;
        in_TDATA[l*32 +: 32] = d;
        in_TKEEP[l*4 +: 4]   = k;
        in_TLAST[l]          = last;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_TVALID = '0; in_TDATA = '0; in_TKEEP = '0; in_TLAST = '0;
        out_TREADY = 1'b0; err_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_TVALID, 0);
        chk("rst_out_bus", {out_TDATA, out_TKEEP, out_TLAST, out_TDEST}, 0);
        chk("rst_in_ready", in_TREADY, 0);
        chk("rst_cnt_err", {pkt_cnt, keep_err}, 0);
        rst_n = 1'b1;
        model_last = 3;
        exp_err = '0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_cnt[i] = 0;
            lq[i].delete();
        end
    endtask

    task automatic add_pkt(input int l, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = $urandom;
            b.l = (i == len - 1);
            b.k = b.l ? 4'($urandom_range(1, 15)) : (($urandom % 4 == 0) ? 4'($urandom) : 4'hF);
            if (!b.l && b.k != 4'hF) exp_err[l] = 1'b1;
            lq[l].push_back(b);
        end
        exp_cnt[l]++;
    endtask

    // Expected output order: whole packets, lanes visited round-robin after the previous winner.
    task automatic plan();
        beat_t c[4][$];
        beat_t b;
        int l;
        for (int i = 0; i < 4; i++) c[i] = lq[i];
        while (c[0].size() + c[1].size() + c[2].size() + c[3].size() > 0) begin
            l = 0;
            for (int off = 4; off >= 1; off--)
                if (c[(model_last + off) % 4].size() > 0) l = (model_last + off) % 4;
            do begin
                b = c[l].pop_front();
                exp_q.push_back({25'b0, 2'(l), b.l, b.k, b.d});
            end while (!b.l);
            model_last = l;
        end
    endtask

    task automatic run_traffic(input bit rand_rdy, input int bound);
        int cyc = 0;
        logic [3:0] acc;
        logic take;
        plan();
        while ((exp_q.size() + lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size()) > 0 && cyc < bound) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (lq[i].size() > 0) set_lane(i, 1'b1, lq[i][0].d, lq[i][0].k, lq[i][0].l);
                else set_lane(i, 1'b0, '0, '0, 1'b0);
            out_TREADY = rand_rdy ? 1'($urandom % 2) : 1'b1;
            #3;
            acc  = in_TVALID & in_TREADY;
            take = out_TVALID & out_TREADY;
            if (in_TREADY != 0)
                chk("ready_rule", {$countones(in_TREADY) == 1, !out_TVALID || out_TREADY}, 2'b11);
            if (take) begin
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else chk("beat", {25'b0, out_TDEST, out_TLAST, out_TKEEP, out_TDATA}, exp_q[0]);
            end
            @(posedge clk);
            for (int i = 0; i < 4; i++) if (acc[i]) void'(lq[i].pop_front());
            if (take && exp_q.size() > 0) void'(exp_q.pop_front());
            cyc++;
        end
        if (cyc >= bound) chk("timeout_left", exp_q.size(), 0);
        @(negedge clk);
        in_TVALID = '0;
        for (int i = 0; i < 4; i++) chk($sformatf("pkt_cnt%0d", i), pkt_cnt[i*8 +: 8], 8'(exp_cnt[i]));
        chk("keep_err", keep_err, exp_err);
    endtask

    initial begin
        do_reset();
        // Lane 2, three beats, latency and counter.
        out_TREADY = 1'b1;
        set_lane(2, 1'b1, 32'hA0, 4'hF, 1'b0);
        @(negedge clk);
        chk("lat_arb", {in_TREADY, out_TVALID}, {4'b0100, 1'b0});
        @(negedge clk);
        chk("lat_a0", {out_TVALID, out_TDEST, out_TLAST, out_TDATA}, {1'b1, 2'd2, 1'b0, 32'hA0});
        set_lane(2, 1'b1, 32'hA1, 4'hF, 1'b0);
        @(negedge clk);
        chk("lat_a1", {out_TVALID, out_TDEST, out_TLAST, out_TDATA}, {1'b1, 2'd2, 1'b0, 32'hA1});
        set_lane(2, 1'b1, 32'hA2, 4'hF, 1'b1);
        @(negedge clk);
        chk("lat_a2", {out_TVALID, out_TDEST, out_TLAST, out_TDATA}, {1'b1, 2'd2, 1'b1, 32'hA2});
        in_TVALID = '0;
        @(negedge clk);
        chk("lat_done", {out_TVALID, pkt_cnt}, {1'b0, 32'h0001_0000});

        // Sticky keep error, clear, and clear colliding with a new error.
        do_reset();
        out_TREADY = 1'b1;
        set_lane(1, 1'b1, 32'h11, 4'h7, 1'b0);
        repeat (2) @(negedge clk);
        set_lane(1, 1'b1, 32'h12, 4'hF, 1'b1);
        @(negedge clk);
        in_TVALID = '0;
        chk("kerr_set", keep_err, 4'b0010);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("kerr_clr", keep_err, 4'b0000);
        set_lane(1, 1'b1, 32'h13, 4'h7, 1'b0);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("kerr_set_wins", keep_err, 4'b0010);
        set_lane(1, 1'b1, 32'h14, 4'hF, 1'b1);
        @(negedge clk);
        in_TVALID = '0;
        chk("kerr_cnt1", pkt_cnt[15:8], 8'd2);

        // Asynchronous reset in the middle of a lane 3 packet.
        set_lane(3, 1'b1, 32'hB0, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        set_lane(3, 1'b1, 32'hB1, 4'hF, 1'b0);
        @(negedge clk);
        set_lane(3, 1'b1, 32'hB2, 4'hF, 1'b0);
        chk("mid_pre_valid", out_TVALID, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async", {out_TVALID, pkt_cnt, keep_err}, 0);
        in_TVALID = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_regrant", in_TREADY, 4'b0010);

        // All lanes with two 2-beat packets: expect lane order 0,1,2,3,0,...
        do_reset();
        for (int r = 0; r < 2; r++) for (int l = 0; l < 4; l++) add_pkt(l, 2);
        run_traffic(1'b0, 200);

        // Random packets with random downstream backpressure.
        for (int round = 0; round < 4; round++) begin
            do_reset();
            for (int l = 0; l < 4; l++)
                for (int p = $urandom_range(0, 4); p > 0; p--) add_pkt(l, $urandom_range(1, 4));
            run_traffic(1'b1, 2000);
        end

        // Counter wrap with single-beat packets on lane 0.
        do_reset();
        for (int p = 0; p < 256; p++) add_pkt(0, 1);
        run_traffic(1'b0, 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tile_stream_merge.md
# tile_stream_merge

Packet-level 4:1 AXI-stream merger on the egress side of a tile's four output stream lanes. It consumes the `stream_out_*` lane bundle of a `Tile_t`-based tile and produces one NoC-bound stream. The source lane is carried in TDEST. It keeps per-lane packet counters and a sticky malformed-TKEEP flag for control-plane readout.

## Interface
- `BW`, 32, lane data width in bits
- `BWB`, BW/8, TKEEP width per lane
- `CNT_W`, 16, width of each per-lane packet counter

Ports:
- `clk_line`  in  1  line clock; the only clock
- `clk_line_rst_low`  in  1  reset, asynchronous assert, active-low
- `in_TVALID`  in  4  per-lane valid, driven by the tile's stream_out_TVALID
- `in_TDATA`  in  4*BW  lane i at [i*BW +: BW]
- `in_TKEEP`  in  4*BWB  lane i at [i*BWB +: BWB]
- `in_TLAST`  in  4  per-lane end of packet
- `in_TREADY`  out  4  per-lane ready, driven back to the tile's stream_out_TREADY
- `out_TVALID`  out  1  merged valid
- `out_TDATA`  out  BW  merged data
- `out_TKEEP`  out  BWB  merged keep
- `out_TLAST`  out  1  merged end of packet
- `out_TDEST`  out  2  index of the source lane
- `out_TREADY`  in  1  downstream ready
- `pkt_cnt`  out  4*CNT_W  packets forwarded per lane, lane i at [i*CNT_W +: CNT_W]
- `keep_err`  out  4  sticky flag per lane: a non-last beat had TKEEP not all ones
- `err_clear`  in  1  synchronous clear of `keep_err`, one-cycle pulse

## Operation
- FSM states: IDLE, LOCKED.
- **IDLE**
  - `in_TREADY` = 0.
  - If any `in_TVALID` is high, round-robin select the first valid lane, starting at `last_grant+1` mod 4.
  - Register the selected lane as `grant` and as `last_grant`, then go to LOCKED.
  - `last_grant` resets to 3, so lane 0 has first priority after reset.
- **LOCKED**
  - `in_TREADY[grant] = !out_TVALID || out_TREADY`. All other lanes see ready = 0.
  - On an accepted beat (`in_TVALID[grant] && in_TREADY[grant]`), load the output register with data, keep, last, and `TDEST = grant`.
  - When the accepted beat has TLAST: increment `pkt_cnt[grant]` (wraps at 2^CNT_W) and go to IDLE.
- **Output register**
  - A single stage.
  - It holds its contents while `out_TVALID && !out_TREADY`.
  - It clears `out_TVALID` when its beat is taken and no new beat is loaded.
- **keep_err**
  - Set bit g when a beat is accepted with `!TLAST` and `TKEEP != all ones`.
  - `err_clear` clears all bits. If a set and a clear occur in the same cycle, set wins.
- The merger never splits or interleaves packets. A lane holding valid without TLAST blocks all other lanes indefinitely; this is by design.

## Timing
- Reset values:
  - All outputs 0: `out_TVALID`, `out_TDATA`, `out_TKEEP`, `out_TLAST`, `out_TDEST`, `in_TREADY`, `pkt_cnt`, `keep_err`.
  - State = IDLE, `last_grant` = 3.
- Latency from `in_TVALID` rising in IDLE:
  - Cycle 0: arbitrate.
  - Cycle 1: accept.
  - Cycle 2: `out_TVALID` high.
- Throughput is one beat per cycle inside a packet.
- There is exactly one bubble cycle (IDLE) between consecutive packets.
- `in_TREADY` has a combinational path from `out_TREADY`. No other input-to-output combinational paths exist.
- Reset mid-packet:
  - `out_TVALID` drops asynchronously.
  - Any partial packet is discarded and counters are cleared.
  - Downstream must tolerate a truncated packet.
- A single-beat packet (TLAST on the first beat) is counted and returns the FSM to IDLE the cycle after acceptance.
- A request arriving on a lane during LOCKED is not granted before the current packet's TLAST is accepted.

## Structure
- Shared package `tile_stream_pkg`:
  - `typedef enum logic {IDLE, LOCKED} merge_state_t`
  - `LANES = 4`
  - `lane_idx_t` (logic [1:0])
- One sub-module, `rr_arbiter4`: combinational round-robin pick.
  - Inputs: `req[3:0]`, `last_grant`.
  - Outputs: `gnt_idx[1:0]`, `gnt_any`.
- Everything else lives in `tile_stream_merge`.

## Test plan
- After reset, lane 2 sends a 3-beat packet 0xA0..0xA2 with `out_TREADY` = 1:
  - Out beats A0, A1, A2 appear on cycles 2..4, TDEST = 2, TLAST on A2.
  - `pkt_cnt[2]` = 1.
- All four lanes hold valid with 2-beat packets:
  - Output lane order is 0, 1, 2, 3, 0.
  - Each packet is contiguous, with one idle cycle between packets.
- `out_TREADY` toggles 1,0,0,1 during a 4-beat packet:
  - No beat is lost or duplicated.
  - `in_TREADY[grant]` tracks the rule above.
- Lane 1 sends a non-last beat with TKEEP = 0x7:
  - `keep_err` = 0b0010.
  - An `err_clear` pulse returns it to 0. With clear and a new error in the same cycle, the bit stays 1.
- Reset is asserted mid-packet on lane 3:
  - `out_TVALID` goes to 0 asynchronously and `pkt_cnt` goes to 0.
  - After release, the next grant goes to the lowest-index valid lane.
- 65536 single-beat packets on lane 0:
  - `pkt_cnt[0]` wraps to 0.
